// File: rtl/seq_alu.sv
// Registered, handshaked ALU with an iterative shift-add multiplier and restoring divider.
// Define ALU_DIV_EN to build the divider; otherwise opcode 0011 reports err.
module seq_alu #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_Sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] ALU_Out,
  output logic [WIDTH-1:0] ALU_Hi,
  output logic             CarryOut,
  output logic             zero,
  output logic             neg,
  output logic             overflow,
  output logic             err,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [1:0] {IDLE, EXEC, BUSY, DONE} state_t;

  localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_MUL = 4'h2, OP_DIV = 4'h3,
                         OP_SHL = 4'h4, OP_SHR = 4'h5, OP_ROL = 4'h6, OP_ROR = 4'h7,
                         OP_AND = 4'h8, OP_OR  = 4'h9, OP_XOR = 4'hA, OP_NOR = 4'hB,
                         OP_NAND = 4'hC, OP_XNOR = 4'hD, OP_GT = 4'hE, OP_EQ = 4'hF;

  state_t           state_q, state_d;
  logic             rdy_q;
  logic [WIDTH-1:0] a_q, b_q, acc_q, acc_d, mq_q, mq_d;
  logic [3:0]       op_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] out_q, out_d, hi_q, hi_d;
  logic             carry_q, carry_d, zero_q, zero_d, neg_q, neg_d;
  logic             ovf_q, ovf_d, err_q, err_d;
  logic [WIDTH:0]   sum, wide;
  logic             accept, is_iter, iter_last, load_res;

  assign accept    = in_ready && in_valid;
  assign iter_last = (cnt_q == CNT_W'(WIDTH));
  assign load_res  = (state_q == EXEC) || (state_q == BUSY && iter_last);

`ifdef ALU_DIV_EN
  assign is_iter = (ALU_Sel == OP_MUL) || (ALU_Sel == OP_DIV && B != '0);
`else
  assign is_iter = (ALU_Sel == OP_MUL);
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = is_iter ? BUSY : EXEC;
      EXEC:    state_d = DONE;
      BUSY:    if (iter_last) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs; rdy_q holds in_ready low until the first edge after reset.
  always_comb begin
    in_ready  = rdy_q && (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // One multiply or divide step; both leave low word/quotient in mq, high word/remainder in acc.
  always_comb begin
    acc_d = acc_q;
    mq_d  = mq_q;
    sum   = '0;
    if (op_q == OP_MUL) begin
      sum   = {1'b0, acc_q} + (mq_q[0] ? {1'b0, b_q} : '0);
      acc_d = sum[WIDTH:1];
      mq_d  = {sum[0], mq_q[WIDTH-1:1]};
    end
`ifdef ALU_DIV_EN
    else begin
      sum = {acc_q, mq_q[WIDTH-1]};
      if (sum >= {1'b0, b_q}) begin
        sum   = sum - {1'b0, b_q};
        acc_d = sum[WIDTH-1:0];
        mq_d  = {mq_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = sum[WIDTH-1:0];
        mq_d  = {mq_q[WIDTH-2:0], 1'b0};
      end
    end
`endif
  end

  // Result and flags for the cycle that enters DONE
  always_comb begin
    out_d   = '0;
    hi_d    = '0;
    carry_d = 1'b0;
    ovf_d   = 1'b0;
    err_d   = 1'b0;
    wide    = '0;
    if (state_q == BUSY) begin
      out_d = mq_q;
      hi_d  = acc_q;
      ovf_d = (op_q == OP_MUL) && (acc_q != '0);
    end else begin
      case (op_q)
        OP_ADD: begin
          wide    = {1'b0, a_q} + {1'b0, b_q};
          out_d   = wide[WIDTH-1:0];
          carry_d = wide[WIDTH];
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (out_d[WIDTH-1] != a_q[WIDTH-1]);
        end
        OP_SUB: begin
          wide    = {1'b0, a_q} - {1'b0, b_q};
          out_d   = wide[WIDTH-1:0];
          carry_d = wide[WIDTH];
          ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (out_d[WIDTH-1] != a_q[WIDTH-1]);
        end
`ifdef ALU_DIV_EN
        OP_DIV: begin
          out_d = '1;
          hi_d  = a_q;
          err_d = 1'b1;
        end
`else
        OP_DIV: err_d = 1'b1;
`endif
        OP_SHL: begin
          out_d   = {a_q[WIDTH-2:0], 1'b0};
          carry_d = a_q[WIDTH-1];
        end
        OP_SHR: begin
          out_d   = {1'b0, a_q[WIDTH-1:1]};
          carry_d = a_q[0];
        end
        OP_ROL:  out_d = {a_q[WIDTH-2:0], a_q[WIDTH-1]};
        OP_ROR:  out_d = {a_q[0], a_q[WIDTH-1:1]};
        OP_AND:  out_d = a_q & b_q;
        OP_OR:   out_d = a_q | b_q;
        OP_XOR:  out_d = a_q ^ b_q;
        OP_NOR:  out_d = ~(a_q | b_q);
        OP_NAND: out_d = ~(a_q & b_q);
        OP_XNOR: out_d = ~(a_q ^ b_q);
        OP_GT:   out_d = {{(WIDTH-1){1'b0}}, a_q > b_q};
        OP_EQ:   out_d = {{(WIDTH-1){1'b0}}, a_q == b_q};
        default: out_d = '0;
      endcase
    end
    zero_d = (out_d == '0);
    neg_d  = out_d[WIDTH-1];
  end

  // Datapath: operand latch, iteration registers and result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      acc_q   <= '0;
      mq_q    <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      hi_q    <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        a_q   <= A;
        b_q   <= B;
        op_q  <= ALU_Sel;
        acc_q <= '0;
        mq_q  <= A;
        cnt_q <= '0;
      end else if (state_q == BUSY && !iter_last) begin
        acc_q <= acc_d;
        mq_q  <= mq_d;
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (load_res) begin
        out_q   <= out_d;
        hi_q    <= hi_d;
        carry_q <= carry_d;
        zero_q  <= zero_d;
        neg_q   <= neg_d;
        ovf_q   <= ovf_d;
        err_q   <= err_d;
      end
    end
  end

  assign ALU_Out  = out_q;
  assign ALU_Hi   = hi_q;
  assign CarryOut = carry_q;
  assign zero     = zero_q;
  assign neg      = neg_q;
  assign overflow = ovf_q;
  assign err      = err_q;

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, registered successor to the team's combinational 8-bit ALU: same 16-entry 4-bit opcode map, operand width set by WIDTH.
- Adds a valid/ready handshake, registered result and flags, and an iterative multiply/divide path yielding a double-width result (low/high words).
- Sits between the datapath register file and the writeback stage of the microprocessor lab core.

Parameters:
WIDTH, 8, operand/result width in bits (>=4)
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
A  in  WIDTH  operand A
B  in  WIDTH  operand B
ALU_Sel  in  4  opcode
in_valid  in  1  operands/opcode valid
in_ready  out  1  block can accept an operation
ALU_Out  out  WIDTH  result (MUL low word, DIV quotient)
ALU_Hi  out  WIDTH  MUL high word, DIV remainder, else 0
CarryOut  out  1  carry / borrow / shifted-out bit
zero  out  1  ALU_Out == 0
neg  out  1  ALU_Out[WIDTH-1]
overflow  out  1  signed overflow (ADD/SUB), ALU_Hi != 0 (MUL)
err  out  1  illegal operation (divide by zero, disabled op)
out_valid  out  1  result and flags valid
out_ready  in  1  consumer accepts result

Behaviour:
- Reset (async, any state): state IDLE, ALU_Out/ALU_Hi/all flags/err/out_valid = 0, iteration counter 0; in-flight op discarded. in_ready = 1 from the first clock edge after reset deasserts.
- Opcodes: 0000 ADD, 0001 SUB, 0010 MUL (unsigned), 0011 DIV (unsigned), 0100 SHL by 1, 0101 SHR logical by 1, 0110 ROL by 1, 0111 ROR by 1, 1000 AND, 1001 OR, 1010 XOR, 1011 NOR, 1100 NAND, 1101 XNOR, 1110 GT (A>B unsigned -> 1 else 0), 1111 EQ (A==B -> 1 else 0).
- FSM: IDLE -> (in_valid) latch A, B, ALU_Sel -> EXEC for simple ops, BUSY for MUL/DIV; EXEC -> DONE after 1 cycle; BUSY -> DONE after exactly WIDTH iterations (shift-add multiply / restoring divide); DONE -> IDLE when out_ready=1.
- in_ready = 1 only in IDLE. out_valid = 1 only in DONE. Outputs and flags are held stable in DONE while out_ready=0.
- Latency (accept edge to out_valid high): 2 cycles for simple ops, WIDTH+2 for MUL/DIV. After the out_valid/out_ready handshake, in_ready is high on the next cycle.
- Arithmetic: ADD: CarryOut = bit WIDTH of A+B. SUB: CarryOut = borrow (A<B unsigned). Overflow on ADD/SUB: operand sign rule. SHL/SHR: CarryOut = bit shifted out. All other ops: CarryOut = 0, overflow = 0.
- MUL: {ALU_Hi, ALU_Out} = A*B (2*WIDTH bits); overflow = (ALU_Hi != 0).
- DIV: ALU_Out = A/B, ALU_Hi = A%B.
- DIV with B==0: no iteration; DONE after 1 cycle; ALU_Out all ones, ALU_Hi = A, err = 1.
- ALU_Hi = 0 for all ops except MUL/DIV. zero/neg are derived from ALU_Out only. err = 0 unless stated otherwise.
- in_valid is ignored outside IDLE; the operands used are those latched at acceptance, and later changes to A/B have no effect.

Optional Feature:
ALU_DIV_EN:
- Defined: DIV implemented as above.
- Undefined: divider logic removed. Opcode 0011 completes in EXEC (2-cycle latency) with ALU_Out = 0, ALU_Hi = 0, err = 1, zero = 1.

Test Plan:
- WIDTH=8, ADD A=F9, B=0A -> ALU_Out=03, CarryOut=1, overflow=0, zero=0, out_valid 2 cycles after accept.
- SUB A=00, B=19 -> ALU_Out=E7, CarryOut=1, neg=1, overflow=0; ADD 7F+01 -> 80, overflow=1, neg=1.
- MUL A=10, B=20 -> ALU_Out=00, ALU_Hi=02, overflow=1, zero=1, out_valid exactly 10 cycles after accept; in_ready=0 throughout.
- DIV A=64, B=07 (ALU_DIV_EN) -> ALU_Out=0E, ALU_Hi=02, err=0. DIV A=5A, B=00 -> ALU_Out=FF, ALU_Hi=5A, err=1 after 2 cycles. Without the macro, opcode 0011 -> ALU_Out=00, err=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling A/B/in_valid -> outputs unchanged, in_ready=0; raise out_ready -> in_ready=1 next cycle.
- Assert reset at cycle 4 of a MUL -> all outputs 0 immediately; after release, ROL A=81 -> ALU_Out=03, result unaffected by the aborted op.
